// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the 8-bit registered ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam logic [ALU_WIDTH-1:0] ALU_DIV0_RESULT = 8'hFF;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_ROL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_AND  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_XOR  = 4'd10,
    ALU_NOR  = 4'd11,
    ALU_NAND = 4'd12,
    ALU_XNOR = 4'd13,
    ALU_GT   = 4'd14,
    ALU_EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational result, carry and magnitude-flag logic of the ALU.
// Define ALU_MUL_DIV_EN to build the multiplier and divider for opcodes 2 and 3.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [3:0]           alu_sel,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 carry,
  output logic                 equal,
  output logic                 greater,
  output logic                 smaller
);

  alu_op_e        op_s;
  logic [8:0]     sum_s;
  logic [8:0]     diff_s;
`ifdef ALU_MUL_DIV_EN
  logic [15:0]    prod_s;
`endif

  assign op_s   = alu_op_e'(alu_sel);
  assign sum_s  = {1'b0, a} + {1'b0, b};
  // Bit 8 of the 9-bit difference is the borrow (set when a < b).
  assign diff_s = {1'b0, a} - {1'b0, b};
`ifdef ALU_MUL_DIV_EN
  assign prod_s = {8'h00, a} * {8'h00, b};
`endif

  // Operation decode: result and carry/borrow/shift-out flag.
  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (op_s)
      ALU_ADD: begin
        result = sum_s[7:0];
        carry  = sum_s[8];
      end
      ALU_SUB: begin
        result = diff_s[7:0];
        carry  = diff_s[8];
      end
`ifdef ALU_MUL_DIV_EN
      ALU_MUL: begin
        result = prod_s[7:0];
        carry  = (prod_s[15:8] != 8'h00);
      end
      ALU_DIV: begin
        if (b == 8'h00) begin
          result = ALU_DIV0_RESULT;
          carry  = 1'b1;
        end else begin
          result = a / b;
          carry  = 1'b0;
        end
      end
`else
      ALU_MUL: begin
        result = 8'h00;
        carry  = 1'b0;
      end
      ALU_DIV: begin
        result = 8'h00;
        carry  = 1'b0;
      end
`endif
      ALU_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      ALU_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
      ALU_ROL:  result = {a[6:0], a[7]};
      ALU_ROR:  result = {a[0], a[7:1]};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_NAND: result = ~(a & b);
      ALU_XNOR: result = ~(a ^ b);
      ALU_GT:   result = (a > b) ? 8'h01 : 8'h00;
      ALU_EQ:   result = (a == b) ? 8'h01 : 8'h00;
      default: begin
        result = 8'h00;
        carry  = 1'b0;
      end
    endcase
  end

  // Magnitude flags are independent of the selected operation.
  always_comb begin
    equal   = (a == b);
    greater = (a > b);
    smaller = (a < b);
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU top: output registers with synchronous active-high reset.
// Optional MUL/DIV support is enabled by defining ALU_MUL_DIV_EN (see alu_core).
module alu_8bit
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [3:0]           alu_sel,
  output logic [ALU_WIDTH-1:0] alu_out,
  output logic                 equal,
  output logic                 greater,
  output logic                 smaller,
  output logic                 carry_out
);

  logic [ALU_WIDTH-1:0] alu_out_d, alu_out_q;
  logic                 carry_out_d, carry_out_q;
  logic                 equal_d, equal_q;
  logic                 greater_d, greater_q;
  logic                 smaller_d, smaller_q;

  alu_core u_core (
    .a       (a),
    .b       (b),
    .alu_sel (alu_sel),
    .result  (alu_out_d),
    .carry   (carry_out_d),
    .equal   (equal_d),
    .greater (greater_d),
    .smaller (smaller_d)
  );

  // Output registers; reset wins over the operation sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q   <= 8'h00;
      carry_out_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      smaller_q   <= 1'b0;
    end else begin
      alu_out_q   <= alu_out_d;
      carry_out_q <= carry_out_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
      smaller_q   <= smaller_d;
    end
  end

  assign alu_out   = alu_out_q;
  assign carry_out = carry_out_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign smaller   = smaller_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed table from the test plan plus random ops
// checked against an arithmetic reference model; a negedge monitor pops and compares.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       equal, greater, smaller, carry_out;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       eq;
    logic       gt;
    logic       lt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .equal     (equal),
    .greater   (greater),
    .smaller   (smaller),
    .carry_out (carry_out)
  );

  function automatic exp_t mk(input logic [7:0] o, input logic c, input logic eq,
                              input logic gt, input logic lt);
    exp_t e;
    e.out = o; e.c = c; e.eq = eq; e.gt = gt; e.lt = lt;
    return e;
  endfunction

  // Reference model from the operation rules, using plain integer arithmetic.
  function automatic exp_t ref_model(input bit r, input int ai, input int bi, input int op);
    int   v;
    bit   c;
    exp_t e;
    if (r) return mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    v = 0;
    c = 1'b0;
    case (op)
      0:  begin v = ai + bi; c = (v > 255); end
      1:  begin v = (ai - bi + 256) % 256; c = (ai < bi); end
`ifdef ALU_MUL_DIV_EN
      2:  begin v = ai * bi; c = (v > 255); end
      3:  begin
            if (bi == 0) begin v = 255; c = 1'b1; end
            else v = ai / bi;
          end
`endif
      4:  begin v = ai * 2; c = (ai >= 128); end
      5:  begin v = ai / 2; c = (ai % 2 == 1); end
      6:  v = (ai * 2) % 256 + ai / 128;
      7:  v = ai / 2 + (ai % 2) * 128;
      8:  v = ai & bi;
      9:  v = ai | bi;
      10: v = ai ^ bi;
      11: v = 255 - (ai | bi);
      12: v = 255 - (ai & bi);
      13: v = 255 - (ai ^ bi);
      14: v = (ai > bi) ? 1 : 0;
      15: v = (ai == bi) ? 1 : 0;
      default: v = 0;
    endcase
    e.out = 8'(v % 256);
    e.c   = c;
    e.eq  = (ai == bi);
    e.gt  = (ai > bi);
    e.lt  = (ai < bi);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one operation; the expected response is queued once the edge samples it.
  task automatic issue(input bit r, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [3:0] op, input exp_t e);
    rst = r; a = ta; b = tb_v; alu_sel = op;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic issue_model(input bit r, input logic [7:0] ta, input logic [7:0] tb_v,
                             input logic [3:0] op);
    issue(r, ta, tb_v, op, ref_model(r, int'(ta), int'(tb_v), int'(op)));
  endtask

  // Monitor: the DUT presents a result every cycle, so compare at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("alu_out",   int'(alu_out),   int'(e.out));
      chk("carry_out", int'(carry_out), int'(e.c));
      chk("equal",     int'(equal),     int'(e.eq));
      chk("greater",   int'(greater),   int'(e.gt));
      chk("smaller",   int'(smaller),   int'(e.lt));
    end
  end

  logic [7:0] sweep_out [16];
  exp_t       zero_e;
  logic [7:0] ra, rb;

  initial begin
    sweep_out = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
`ifndef ALU_MUL_DIV_EN
    sweep_out[2] = 8'h00;
    sweep_out[3] = 8'h00;
`endif
    zero_e = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; a = 8'h55; b = 8'h11; alu_sel = 4'd0;
    #1;
    issue(1'b1, 8'h55, 8'h11, 4'd0, zero_e);
    issue(1'b1, 8'hA3, 8'h3A, 4'd2, zero_e);

    // Opcode sweep with a one-cycle reset inserted after opcode 7.
    for (int i = 0; i < 16; i++) begin
      if (i == 8) issue(1'b1, 8'h0A, 8'h02, 4'd8, zero_e);
      issue(1'b0, 8'h0A, 8'h02, 4'(i), mk(sweep_out[i], 1'b0, 1'b0, 1'b1, 1'b0));
    end

    issue(1'b0, 8'hF6, 8'h0A, 4'd0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'hF6, 8'h0A, 4'd1, mk(8'hEC, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'hF6, 8'h0A, 4'd4, mk(8'hEC, 1'b1, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'hF6, 8'h0A, 4'd7, mk(8'h7B, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'h05, 8'h09, 4'd1, mk(8'hFC, 1'b1, 1'b0, 1'b0, 1'b1));
    issue(1'b0, 8'h33, 8'h33, 4'd15, mk(8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef ALU_MUL_DIV_EN
    issue(1'b0, 8'h40, 8'h00, 4'd3, mk(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'h20, 8'h10, 4'd2, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
`else
    issue(1'b0, 8'h40, 8'h00, 4'd3, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(1'b0, 8'h20, 8'h10, 4'd2, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
`endif

    // Random traffic, biased toward b == 0, a == b and occasional resets.
    for (int n = 0; n < 400; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: rb = 8'h00;
        1: rb = ra;
        default: ;
      endcase
      issue_model(($urandom_range(0, 24) == 0), ra, rb, 4'($urandom_range(0, 15)));
    end

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
